// File: rtl/audio_i2s_receiver_if.sv
// Pin bundle between an I2S source and the receiver: serial BCK/LRCK/DATA in,
// parallel stereo words and status strobes out.
interface audio_i2s_receiver_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  iAUD_BCK;
  logic                  iAUD_LRCK;
  logic                  iAUD_DATA;
  logic [DATA_WIDTH-1:0] o_lsound_in;
  logic [DATA_WIDTH-1:0] o_rsound_in;
  logic                  o_sample_valid;
  logic                  o_short_frame;
  logic                  o_locked;

  modport master (
    output iAUD_BCK, iAUD_LRCK, iAUD_DATA,
    input  o_lsound_in, o_rsound_in, o_sample_valid, o_short_frame, o_locked
  );

  modport slave (
    input  iAUD_BCK, iAUD_LRCK, iAUD_DATA,
    output o_lsound_in, o_rsound_in, o_sample_valid, o_short_frame, o_locked
  );
endinterface

// File: rtl/audio_i2s_receiver.sv
// Oversampling I2S receiver: synchronizes BCK/LRCK/DATA into OSC_CLK, assembles
// MSB-first left/right words and commits each complete stereo pair as one strobe.
module audio_i2s_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_MAX   = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                OSC_CLK,
  input  logic                reset_reg,
  audio_i2s_receiver_if.slave aud
);

  localparam int CNT_W = $clog2(SLOT_MAX + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] DW_C   = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] SLOT_C = CNT_W'(SLOT_MAX);
  localparam logic [WD_W-1:0]  TO_C   = WD_W'(TIMEOUT);

  // PH_NONE: no channel boundary seen yet, so bit alignment is unknown.
  typedef enum logic [1:0] {
    PH_NONE,
    PH_WAIT_LEFT,
    PH_HAVE_LEFT
  } phase_e;

  logic [2:0]            bck_sync_q;
  logic [1:0]            lrck_sync_q;
  logic [1:0]            data_sync_q;
  logic                  bck_rise;
  logic                  lrck_s2;
  logic                  data_s2;

  phase_e                phase_q,     phase_d;
  logic                  lrck_prev_q, lrck_prev_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [WD_W-1:0]       wd_q,        wd_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic [DATA_WIDTH-1:0] l_hold_q,    l_hold_d;
  logic [DATA_WIDTH-1:0] l_out_q,     l_out_d;
  logic [DATA_WIDTH-1:0] r_out_q,     r_out_d;
  logic                  valid_q,     valid_d;
  logic                  short_q,     short_d;
  logic                  locked_q,    locked_d;

  assign bck_rise = bck_sync_q[1] & ~bck_sync_q[2];
  assign lrck_s2  = lrck_sync_q[1];
  assign data_s2  = data_sync_q[1];

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned and no latch is inferred.
    phase_d     = phase_q;
    lrck_prev_d = lrck_prev_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    l_hold_d    = l_hold_q;
    l_out_d     = l_out_q;
    r_out_d     = r_out_q;
    locked_d    = locked_q;
    valid_d     = 1'b0;
    short_d     = 1'b0;

    if (bck_rise)            wd_d = '0;
    else if (wd_q != TO_C)   wd_d = wd_q + 1'b1;
    else                     wd_d = wd_q;

    if (bck_rise) begin
      if (lrck_s2 != lrck_prev_q) begin
        // Boundary edge carries the one-bit-delay slot; its data bit is dropped.
        lrck_prev_d = lrck_s2;
        cnt_d       = '0;
        if (phase_q == PH_NONE) begin
          phase_d = PH_WAIT_LEFT;
        end else if (cnt_q >= DW_C) begin
          if (!lrck_prev_q) begin
            l_hold_d = shift_q;
            phase_d  = PH_HAVE_LEFT;
          end else begin
            if (phase_q == PH_HAVE_LEFT) begin
              l_out_d  = l_hold_q;
              r_out_d  = shift_q;
              valid_d  = 1'b1;
              locked_d = 1'b1;
            end
            phase_d = PH_WAIT_LEFT;
          end
        end else begin
          short_d  = 1'b1;
          locked_d = 1'b0;
          phase_d  = PH_WAIT_LEFT;
        end
      end else begin
        if (cnt_q < DW_C)   shift_d = {shift_q[DATA_WIDTH-2:0], data_s2};
        if (cnt_q != SLOT_C) cnt_d  = cnt_q + 1'b1;
      end
    end else if (wd_d == TO_C) begin
      // Stream lost: forget alignment and any half-received pair, keep the words.
      locked_d = 1'b0;
      phase_d  = PH_NONE;
    end
  end

  always_ff @(posedge OSC_CLK or posedge reset_reg) begin
    if (reset_reg) begin
      bck_sync_q  <= '0;
      lrck_sync_q <= '0;
      data_sync_q <= '0;
      phase_q     <= PH_NONE;
      lrck_prev_q <= 1'b0;
      cnt_q       <= '0;
      wd_q        <= '0;
      shift_q     <= '0;
      l_hold_q    <= '0;
      l_out_q     <= '0;
      r_out_q     <= '0;
      valid_q     <= 1'b0;
      short_q     <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge values, independent of statement order.
      bck_sync_q  <= {bck_sync_q[1:0], aud.iAUD_BCK};
      lrck_sync_q <= {lrck_sync_q[0], aud.iAUD_LRCK};
      data_sync_q <= {data_sync_q[0], aud.iAUD_DATA};
      phase_q     <= phase_d;
      lrck_prev_q <= lrck_prev_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      shift_q     <= shift_d;
      l_hold_q    <= l_hold_d;
      l_out_q     <= l_out_d;
      r_out_q     <= r_out_d;
      valid_q     <= valid_d;
      short_q     <= short_d;
      locked_q    <= locked_d;
    end
  end

  assign aud.o_lsound_in    = l_out_q;
  assign aud.o_rsound_in    = r_out_q;
  assign aud.o_sample_valid = valid_q;
  assign aud.o_short_frame  = short_q;
  assign aud.o_locked       = locked_q;

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Directed bench for audio_i2s_receiver: table of stereo frames plus hand-written
// stall, reset and 4x-oversampling sequences.
module tb_audio_i2s_receiver;

  localparam int DW       = 16;
  localparam int SLOT_MAX = 32;
  localparam int TIMEOUT  = 256;
  localparam int SYNC_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_i2s_receiver_if #(.DATA_WIDTH(DW)) aud ();

  audio_i2s_receiver #(
    .DATA_WIDTH (DW),
    .SLOT_MAX   (SLOT_MAX),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .OSC_CLK   (clk),
    .reset_reg (rst),
    .aud       (aud.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge.
  int   cyc = 0;
  int   valid_cnt = 0, short_cnt = 0, valid_wide = 0, short_wide = 0;
  int   valid_cyc = 0, fall_cyc = 0;
  logic prev_valid = 1'b0, prev_short = 1'b0, prev_locked = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (aud.o_sample_valid === 1'b1) begin
      valid_cnt++;
      valid_cyc = cyc;
      if (prev_valid) valid_wide++;
    end
    if (aud.o_short_frame === 1'b1) begin
      short_cnt++;
      if (prev_short) short_wide++;
    end
    if (prev_locked && aud.o_locked !== 1'b1) fall_cyc = cyc;
    prev_valid  = (aud.o_sample_valid === 1'b1);
    prev_short  = (aud.o_short_frame === 1'b1);
    prev_locked = (aud.o_locked === 1'b1);
  end

  // BCK half-period in OSC_CLK cycles; LRCK/DATA change with the BCK fall.
  int hclk = 3;
  int last_raise = 0;

  task automatic bck_bit(input logic lr, input logic d);
    aud.iAUD_BCK  = 1'b0;
    aud.iAUD_LRCK = lr;
    aud.iAUD_DATA = d;
    repeat (hclk) @(negedge clk);
    aud.iAUD_BCK = 1'b1;
    last_raise   = cyc;
    repeat (hclk) @(negedge clk);
  endtask

  // Slots 1..nbck-1 of a half-frame; slot 0 is the boundary edge sent separately.
  task automatic half_body(input logic lr, input logic [31:0] w, input int wbits, input int nbck);
    for (int i = 1; i < nbck; i++)
      bck_bit(lr, (i <= wbits) ? w[wbits-i] : 1'b1);
  endtask

  // Left body, right boundary, right body, next-left boundary (which commits the pair).
  task automatic frame(input logic [31:0] l, input logic [31:0] r, input int wbits,
                       input int nbl, input int nbr);
    half_body(1'b0, l, wbits, nbl);
    bck_bit(1'b1, 1'b1);
    half_body(1'b1, r, wbits, nbr);
    bck_bit(1'b0, 1'b1);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    int          wbits;
    int          nbl;
    int          nbr;
    logic [31:0] l;
    logic [31:0] r;
    logic        exp_valid;
    int          exp_short;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic        exp_locked;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int v0, s0;
    logic [15:0] rl, rr;

    // nbl/nbr count BCK edges per half including the boundary slot, so a half
    // of N edges delivers N-1 data bits.
    vecs[0]  = '{16, 32, 32, 32'h8001,   32'h7FFE,   1'b1, 0, 16'h8001, 16'h7FFE, 1'b1};
    vecs[1]  = '{16, 32, 32, 32'h1234,   32'hABCD,   1'b1, 0, 16'h1234, 16'hABCD, 1'b1};
    vecs[2]  = '{16, 17, 17, 32'hFFFF,   32'h0000,   1'b1, 0, 16'hFFFF, 16'h0000, 1'b1};
    vecs[3]  = '{24, 32, 32, 32'hA5C3F0, 32'h123456, 1'b1, 0, 16'hA5C3, 16'h1234, 1'b1};
    vecs[4]  = '{16, 48, 48, 32'h0F0F,   32'hF0F0,   1'b1, 0, 16'h0F0F, 16'hF0F0, 1'b1};
    vecs[5]  = '{16, 10, 32, 32'h1111,   32'h2222,   1'b0, 1, 16'h0F0F, 16'hF0F0, 1'b0};
    vecs[6]  = '{16, 32, 32, 32'h5555,   32'hAAAA,   1'b1, 0, 16'h5555, 16'hAAAA, 1'b1};
    vecs[7]  = '{16, 16, 32, 32'h3333,   32'h4444,   1'b0, 1, 16'h5555, 16'hAAAA, 1'b0};
    vecs[8]  = '{16, 32, 32, 32'h6666,   32'h7777,   1'b1, 0, 16'h6666, 16'h7777, 1'b1};
    vecs[9]  = '{16, 32, 16, 32'h8888,   32'h9999,   1'b0, 1, 16'h6666, 16'h7777, 1'b0};
    vecs[10] = '{16, 32, 32, 32'hC3C3,   32'h3C3C,   1'b1, 0, 16'hC3C3, 16'h3C3C, 1'b1};

    aud.iAUD_BCK  = 1'b0;
    aud.iAUD_LRCK = 1'b0;
    aud.iAUD_DATA = 1'b0;
    repeat (3) @(negedge clk);
    check("reset lsound", 32'(aud.o_lsound_in), 32'h0);
    check("reset rsound", 32'(aud.o_rsound_in), 32'h0);
    check("reset valid",  32'(aud.o_sample_valid), 32'h0);
    check("reset short",  32'(aud.o_short_frame), 32'h0);
    check("reset locked", 32'(aud.o_locked), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Partial left, phase boundary into a full right, then a boundary that discards it.
    half_body(1'b0, 32'h0, 16, 4);
    bck_bit(1'b1, 1'b1);
    half_body(1'b1, 32'hFFFF, 16, 32);
    bck_bit(1'b0, 1'b1);
    settle();
    check("preamble valid count", valid_cnt, 0);
    check("preamble short count", short_cnt, 0);
    check("preamble locked", 32'(aud.o_locked), 32'h0);

    for (int i = 0; i < 11; i++) begin
      v0 = valid_cnt;
      s0 = short_cnt;
      frame(vecs[i].l, vecs[i].r, vecs[i].wbits, vecs[i].nbl, vecs[i].nbr);
      settle();
      check($sformatf("vec%0d valid", i), valid_cnt - v0, 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d short", i), short_cnt - s0, vecs[i].exp_short);
      check($sformatf("vec%0d lsound", i), 32'(aud.o_lsound_in), 32'(vecs[i].exp_l));
      check($sformatf("vec%0d rsound", i), 32'(aud.o_rsound_in), 32'(vecs[i].exp_r));
      check($sformatf("vec%0d locked", i), 32'(aud.o_locked), 32'(vecs[i].exp_locked));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d latency", i), valid_cyc - last_raise, SYNC_LAT);
    end

    // BCK stall: lock must drop TIMEOUT cycles after the edge that registered the last bck_rise.
    v0 = valid_cnt;
    aud.iAUD_BCK = 1'b0;
    repeat (300) @(negedge clk);
    check("stall locked", 32'(aud.o_locked), 32'h0);
    check("stall fall time", fall_cyc - last_raise, TIMEOUT + SYNC_LAT);
    check("stall lsound hold", 32'(aud.o_lsound_in), 32'hC3C3);
    check("stall rsound hold", 32'(aud.o_rsound_in), 32'h3C3C);
    check("stall no valid", valid_cnt - v0, 0);

    s0 = short_cnt;
    frame(32'h1357, 32'h2468, 16, 32, 32);
    settle();
    check("resume first frame valid", valid_cnt - v0, 0);
    check("resume first frame short", short_cnt - s0, 0);
    frame(32'h9ABC, 32'hDEF0, 16, 32, 32);
    settle();
    check("resume valid", valid_cnt - v0, 1);
    check("resume lsound", 32'(aud.o_lsound_in), 32'h9ABC);
    check("resume rsound", 32'(aud.o_rsound_in), 32'hDEF0);
    check("resume locked", 32'(aud.o_locked), 32'h1);

    // Reset in the middle of a left word clears outputs without a clock edge.
    half_body(1'b0, 32'hBEEF, 16, 9);
    @(negedge clk);
    aud.iAUD_BCK = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset lsound", 32'(aud.o_lsound_in), 32'h0);
    check("midreset rsound", 32'(aud.o_rsound_in), 32'h0);
    check("midreset locked", 32'(aud.o_locked), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    aud.iAUD_LRCK = 1'b1;
    repeat (3) @(negedge clk);

    v0 = valid_cnt;
    s0 = short_cnt;
    for (int i = 0; i < 5; i++) bck_bit(1'b1, 1'b1);
    bck_bit(1'b0, 1'b1);
    settle();
    check("post-reset partial valid", valid_cnt - v0, 0);
    check("post-reset partial short", short_cnt - s0, 1);
    frame(32'hCAFE, 32'hF00D, 16, 32, 32);
    settle();
    check("post-reset valid", valid_cnt - v0, 1);
    check("post-reset lsound", 32'(aud.o_lsound_in), 32'hCAFE);
    check("post-reset rsound", 32'(aud.o_rsound_in), 32'hF00D);

    // BCK at exactly a quarter of OSC_CLK with random words.
    hclk = 2;
    v0 = valid_cnt;
    s0 = short_cnt;
    for (int f = 0; f < 100; f++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      frame({16'h0, rl}, {16'h0, rr}, 16, 20, 20);
      settle();
      check($sformatf("fast frame %0d pair", f),
            {aud.o_lsound_in, aud.o_rsound_in}, {rl, rr});
    end
    check("fast valid count", valid_cnt - v0, 100);
    check("fast short count", short_cnt - s0, 0);
    check("fast locked", 32'(aud.o_locked), 32'h1);

    check("valid strobe width", valid_wide, 0);
    check("short strobe width", short_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_i2s_receiver.md
# audio_i2s_receiver

Serial-to-parallel I2S receiver for the synthesizer audio path, the receive-side counterpart of the I2S driver that serializes `lsound_out`/`rsound_out`. It oversamples an externally supplied bit clock, word clock and serial data line with `OSC_CLK`. It assembles left/right sample words and presents each completed stereo pair as a one-cycle strobe with parallel data. Targets are ADC/line-in capture and loopback verification of the synth output stream.

## Interface
- `DATA_WIDTH`, 16: captured word width in bits (MSB-first); 24 for 24-bit audio builds.
- `SLOT_MAX`, 32: max BCK rising edges counted per half-frame; the counter saturates here.
- `TIMEOUT`, 256: OSC_CLK cycles without a BCK rising edge before lock is dropped.

- `OSC_CLK`  in  1  system clock; all state on rising edge.
- `reset_reg`  in  1  reset, asynchronous, active-high.
- `iAUD_BCK`  in  1  I2S bit clock, asynchronous to OSC_CLK.
- `iAUD_LRCK`  in  1  I2S word clock; 0 = left, 1 = right.
- `iAUD_DATA`  in  1  I2S serial data.
- `o_lsound_in`  out  DATA_WIDTH  last committed left word.
- `o_rsound_in`  out  DATA_WIDTH  last committed right word.
- `o_sample_valid`  out  1  one-cycle strobe when a new L/R pair is on the outputs.
- `o_short_frame`  out  1  one-cycle strobe when a half-frame carried fewer than DATA_WIDTH bits.
- `o_locked`  out  1  high while a well-formed stream is being received.

## Operation
- **Synchronizers:** BCK, LRCK and DATA each pass through 2 flops (s1, s2). A third BCK flop (s3) gives `bck_rise = s2 & ~s3`. All data-path actions happen only in cycles where `bck_rise` is high, and use the s2 values of LRCK and DATA.
- **Channel boundary:** detected on a `bck_rise` where LRCK(s2) differs from the registered `lrck_prev`.
  - The data bit on that edge is the I2S one-bit-delay slot. It is discarded.
  - The bit counter clears to 0 and `lrck_prev` updates.
- **Bit capture:** on each later `bck_rise` in the same half-frame:
  - If count < DATA_WIDTH, shift DATA into the LSB of the shift register (MSB arrives first).
  - Count increments and saturates at SLOT_MAX. Bits beyond DATA_WIDTH are ignored, so longer words are truncated to their top DATA_WIDTH bits.
- **Commit at boundary, count ≥ DATA_WIDTH:**
  - Old channel left: shift register → `l_hold`; set `have_left`.
  - Old channel right with `have_left` set: `l_hold` → `o_lsound_in`, shift register → `o_rsound_in`; pulse `o_sample_valid`; set `o_locked`; clear `have_left`.
  - Old channel right with `have_left` clear: discard.
- **Commit at boundary, count < DATA_WIDTH:**
  - Pulse `o_short_frame`, discard the word, clear `have_left`, clear `o_locked`.
  - The first boundary after reset is exempt: it only establishes phase, with no commit and no error.
- **Watchdog:** a counter clears on every `bck_rise` and saturates at TIMEOUT. On reaching TIMEOUT it clears `o_locked`, `have_left` and the phase-established flag. Output words hold their values.
- **Simultaneous events:** a timeout and a `bck_rise` cannot coincide, because `bck_rise` clears the counter first. A short frame and a valid commit are mutually exclusive per boundary.
- **Reset:** all outputs, the shift register, `l_hold`, counters and flags go to 0; `lrck_prev` goes to 0. A reset mid-frame abandons the partial word. The first `o_sample_valid` after reset requires a full left half-frame followed by a full right half-frame, both after the phase-establishing boundary.

## Timing
- Outputs are registered. `o_sample_valid` and `o_short_frame` are high for exactly 1 OSC_CLK cycle.
- Latency: the right→left BCK rising edge is first captured in s1 at OSC_CLK edge 1. Outputs and the strobe update at edge 3 and are visible for the following cycle.
- `o_lsound_in`/`o_rsound_in` change only together with `o_sample_valid` and are stable until the next strobe.
- Requirement: f_OSC_CLK ≥ 4 × f_BCK, with BCK high and low each ≥ 2 OSC_CLK periods. Behaviour is undefined below this.
- LRCK and DATA must be stable around the BCK rising edge, per I2S (they change on the BCK falling edge).

## Test plan
- **Basic pair:** reset, then 32 BCK/frame, DATA_WIDTH=16, L=16'h8001, R=16'h7FFE, three frames → first `o_sample_valid` at the end of the first full right half-frame after the phase boundary; outputs 8001/7FFE; `o_locked`=1; strobe 1 cycle wide.
- **Truncation:** 64 BCK/frame carrying 24-bit words L=24'hA5C3F0, R=24'h123456 → `o_lsound_in`=16'hA5C3, `o_rsound_in`=16'h1234.
- **Short frame:** locked stream, then one left half-frame of 10 BCK → `o_short_frame` pulse, no `o_sample_valid` for that pair, `o_locked`=0. The next good L/R pair produces valid and relocks.
- **BCK stall:** locked, then BCK held low for 300 OSC_CLK → `o_locked` falls exactly TIMEOUT=256 cycles after the last `bck_rise`; output words unchanged; resumed stream relocks after one phase boundary plus a full pair.
- **Reset mid-operation:** assert `reset_reg` mid-left-word → all outputs 0 immediately. After release, starting mid-right channel, no strobe until a complete left+right pair.
- **Oversampling limit:** f_OSC = 4 × f_BCK with random L/R data over 100 frames → every pair received bit-exact, no `o_short_frame`.
